switch_cell_tx: RTL and testbench

SWITCH_CELL_TX -- requirements
Module: switch_cell_tx

---
 rtl/swc_cell_pkg.sv | 37 +++
 rtl/switch_cell_tx_if.sv | 28 ++
 rtl/swc_byte_packer.sv | 59 +++++
 rtl/switch_cell_tx.sv | 146 ++++++++++++++
 tb/tb_switch_cell_tx.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/swc_cell_pkg.sv
// rtl/swc_cell_pkg.sv - shared widths, descriptor layout, FSM encoding and helpers for the cell TX path
package swc_cell_pkg;

    localparam int BEAT_W         = 128;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_BEAT = BEAT_W / BYTE_W;
    localparam int DESC_W         = 16;
    localparam int PM_LSB         = 8;
    localparam int PM_W           = 4;
    localparam int BEATS_LSB      = 0;
    localparam int BEATS_W        = 8;
    localparam int STAT_W         = 16;
    localparam int MIN_BEATS_DEF  = 4;
    localparam int MAX_BEATS_DEF  = 95;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PASS = 3'd1,
        ST_DROP = 3'd2,
        ST_PAD  = 3'd3,
        ST_PTR  = 3'd4
    } swc_state_e;

    function automatic logic [DESC_W-1:0] make_desc(input logic [PM_W-1:0] pm,
                                                    input logic [BEATS_W-1:0] beats);
        logic [DESC_W-1:0] d;
        d = '0;
        d[PM_LSB +: PM_W]       = pm;
        d[BEATS_LSB +: BEATS_W] = beats;
        return d;
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/switch_cell_tx_if.sv
// rtl/switch_cell_tx_if.sv - byte ingress stream, cell fifo write ports and core backpressure
interface switch_cell_tx_if;
    import swc_cell_pkg::*;

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_sof;
    logic              in_eof;
    logic [PM_W-1:0]   in_portmap;
    logic [BEAT_W-1:0] i_cell_data_fifo_din;
    logic              i_cell_data_fifo_wr;
    logic [DESC_W-1:0] i_cell_ptr_fifo_din;
    logic              i_cell_ptr_fifo_wr;
    logic              i_cell_bp;

    modport master (
        output in_data, in_valid, in_sof, in_eof, in_portmap, i_cell_bp,
        input  i_cell_data_fifo_din, i_cell_data_fifo_wr,
               i_cell_ptr_fifo_din, i_cell_ptr_fifo_wr
    );

    modport slave (
        input  in_data, in_valid, in_sof, in_eof, in_portmap, i_cell_bp,
        output i_cell_data_fifo_din, i_cell_data_fifo_wr,
               i_cell_ptr_fifo_din, i_cell_ptr_fifo_wr
    );

endinterface

// File: rtl/swc_byte_packer.sv
// rtl/swc_byte_packer.sv - 8-to-128 byte accumulator, flushes a partial beat on eof, emits zero pad beats
module swc_byte_packer
    import swc_cell_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_data_i,
    input  logic              flush_i,
    input  logic              pad_i,
    output logic              emit_o,
    output logic [BEAT_W-1:0] beat_data_o,
    output logic              beat_wr_o
);

    logic [BEAT_W-1:0] acc_q;
    logic [BEAT_W-1:0] acc_d;
    logic [BEAT_W-1:0] beat_q;
    logic [3:0]        idx_q;
    logic              wr_q;
    logic [6:0]        bit_hi;

    // Byte k of a beat occupies the k-th byte from the top.
    assign bit_hi = 7'(BEAT_W - 1) - {idx_q, 3'b000};

    always_comb begin
        acc_d = acc_q;
        acc_d[bit_hi -: BYTE_W] = byte_data_i;
    end

    assign emit_o = (byte_valid_i & ((idx_q == 4'(BYTES_PER_BEAT - 1)) | flush_i)) | pad_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            beat_q <= '0;
            idx_q  <= '0;
            wr_q   <= 1'b0;
        end else begin
            wr_q <= emit_o;
            if (byte_valid_i) begin
                if (emit_o) begin
                    beat_q <= acc_d;
                    acc_q  <= '0;
                    idx_q  <= '0;
                end else begin
                    acc_q  <= acc_d;
                    idx_q  <= idx_q + 4'd1;
                end
            end else if (pad_i) begin
                beat_q <= '0;
            end
        end
    end

    assign beat_data_o = beat_q;
    assign beat_wr_o   = wr_q;

endmodule

// File: rtl/switch_cell_tx.sv
// rtl/switch_cell_tx.sv - frame-to-cell transmit FSM; statistics counters built only with SWC_TX_STATS_EN
module switch_cell_tx
    import swc_cell_pkg::*;
#(
    parameter int MAX_BEATS = MAX_BEATS_DEF,
    parameter int MIN_BEATS = MIN_BEATS_DEF
)(
    input  logic              clk,
    input  logic              rst,
    switch_cell_tx_if.slave   bus,
    output logic [STAT_W-1:0] stat_frames,
    output logic [STAT_W-1:0] stat_drop_bp,
    output logic [STAT_W-1:0] stat_drop_nomap
);

    localparam logic [BEATS_W-1:0] MAX_B = BEATS_W'(MAX_BEATS);
    localparam logic [BEATS_W-1:0] MIN_B = BEATS_W'(MIN_BEATS);

    swc_state_e         state_q;
    logic [BEATS_W-1:0] beats_q;
    logic [BEATS_W-1:0] beats_base;
    logic [BEATS_W-1:0] beats_d;
    logic [PM_W-1:0]    portmap_q;
    logic               drop_pend_q;
    logic               drop_pend_d;
    logic [DESC_W-1:0]  ptr_din_q;
    logic               ptr_wr_q;
    logic               sof_ev;
    logic               eof_ev;
    logic               admit;
    logic               accept;
    logic               pad;
    logic               emit;

    assign sof_ev = bus.in_valid & bus.in_sof;
    assign eof_ev = bus.in_valid & bus.in_eof;
    assign admit  = (state_q == ST_IDLE) & sof_ev & ~bus.i_cell_bp & (|bus.in_portmap);
    assign accept = admit | ((state_q == ST_PASS) & bus.in_valid & (beats_q < MAX_B));
    assign pad    = (state_q == ST_PAD);

    assign beats_base = (state_q == ST_IDLE) ? '0 : beats_q;
    assign beats_d    = beats_base + {{(BEATS_W-1){1'b0}}, emit};

    // A new SOF arriving while the previous frame pads or posts its descriptor
    // is dropped; remember it until its eof shows up.
    assign drop_pend_d = (drop_pend_q | sof_ev) & ~eof_ev;

    swc_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .byte_valid_i (accept),
        .byte_data_i  (bus.in_data),
        .flush_i      (bus.in_eof),
        .pad_i        (pad),
        .emit_o       (emit),
        .beat_data_o  (bus.i_cell_data_fifo_din),
        .beat_wr_o    (bus.i_cell_data_fifo_wr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beats_q     <= '0;
            portmap_q   <= '0;
            drop_pend_q <= 1'b0;
            ptr_din_q   <= '0;
            ptr_wr_q    <= 1'b0;
        end else begin
            ptr_wr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (admit) begin
                        portmap_q <= bus.in_portmap;
                        beats_q   <= beats_d;
                        if (eof_ev)
                            state_q <= (beats_d < MIN_B) ? ST_PAD : ST_PTR;
                        else
                            state_q <= ST_PASS;
                    end else if (sof_ev && !eof_ev) begin
                        state_q <= ST_DROP;
                    end
                end
                ST_PASS: begin
                    beats_q <= beats_d;
                    if (eof_ev)
                        state_q <= (beats_d < MIN_B) ? ST_PAD : ST_PTR;
                end
                ST_PAD: begin
                    beats_q     <= beats_d;
                    drop_pend_q <= drop_pend_d;
                    if (beats_d >= MIN_B)
                        state_q <= ST_PTR;
                end
                ST_PTR: begin
                    ptr_wr_q    <= 1'b1;
                    ptr_din_q   <= make_desc(portmap_q, beats_q);
                    drop_pend_q <= 1'b0;
                    state_q     <= drop_pend_d ? ST_DROP : ST_IDLE;
                end
                ST_DROP: begin
                    if (eof_ev)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.i_cell_ptr_fifo_din = ptr_din_q;
    assign bus.i_cell_ptr_fifo_wr  = ptr_wr_q;

`ifdef SWC_TX_STATS_EN
    logic [STAT_W-1:0] frames_q;
    logic [STAT_W-1:0] drop_bp_q;
    logic [STAT_W-1:0] drop_nomap_q;
    logic              ev_frame;
    logic              ev_bp;
    logic              ev_nomap;

    assign ev_frame = (state_q == ST_PTR);
    assign ev_bp    = sof_ev & (((state_q == ST_IDLE) & bus.i_cell_bp) |
                                (state_q == ST_PAD) | (state_q == ST_PTR));
    assign ev_nomap = sof_ev & (state_q == ST_IDLE) & ~bus.i_cell_bp & ~(|bus.in_portmap);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_q     <= '0;
            drop_bp_q    <= '0;
            drop_nomap_q <= '0;
        end else begin
            if (ev_frame) frames_q     <= sat_inc(frames_q);
            if (ev_bp)    drop_bp_q    <= sat_inc(drop_bp_q);
            if (ev_nomap) drop_nomap_q <= sat_inc(drop_nomap_q);
        end
    end

    assign stat_frames     = frames_q;
    assign stat_drop_bp    = drop_bp_q;
    assign stat_drop_nomap = drop_nomap_q;
`else
    assign stat_frames     = '0;
    assign stat_drop_bp    = '0;
    assign stat_drop_nomap = '0;
`endif

endmodule

// File: tb/tb_switch_cell_tx.sv
// tb/tb_switch_cell_tx.sv - scoreboard bench for switch_cell_tx
module tb_switch_cell_tx;

    localparam int MAX_BEATS = 95;
    localparam int MIN_BEATS = 4;
`ifdef SWC_TX_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] stat_frames;
    logic [15:0] stat_drop_bp;
    logic [15:0] stat_drop_nomap;

    switch_cell_tx_if bus ();

    switch_cell_tx #(.MAX_BEATS(MAX_BEATS), .MIN_BEATS(MIN_BEATS)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .stat_frames     (stat_frames),
        .stat_drop_bp    (stat_drop_bp),
        .stat_drop_nomap (stat_drop_nomap)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_wr = -100;
    int cnt_frames = 0;
    int cnt_bp = 0;
    int cnt_nomap = 0;
    logic [127:0] exp_data[$];
    logic [16:0]  exp_desc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_stat(input int v);
        return STATS_ON ? v : 0;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            logic [16:0] e;
            if (bus.i_cell_data_fifo_wr || bus.i_cell_ptr_fifo_wr)
                check("strobe_excl", 128'(bus.i_cell_data_fifo_wr & bus.i_cell_ptr_fifo_wr), 128'(0));
            if (bus.i_cell_data_fifo_wr) begin
                if (exp_data.size() == 0)
                    check("data_unexpected", 128'(1), 128'(0));
                else
                    check("data_beat", bus.i_cell_data_fifo_din, exp_data.pop_front());
                last_wr = cyc;
            end
            if (bus.i_cell_ptr_fifo_wr) begin
                if (exp_desc.size() == 0) begin
                    check("desc_unexpected", 128'(1), 128'(0));
                end else begin
                    e = exp_desc.pop_front();
                    check("desc", 128'(bus.i_cell_ptr_fifo_din), 128'(e[15:0]));
                    if (e[16])
                        check("desc_gap", 128'(cyc - last_wr), 128'(1));
                end
            end
        end
    end

    task automatic send_frame(input int len, input logic [3:0] pm, input logic bp_sof,
                              input logic bp_mid, input logic force_drop, input int cut);
        int n;
        int nb;
        logic [7:0] b;
        logic [127:0] beat;
        logic admit;
        n = (cut > 0) ? cut : len;
        admit = !bp_sof && (pm != 4'd0) && !force_drop;
        beat = '0;
        nb = 0;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (admit && i < 16 * MAX_BEATS) begin
                beat[127 - 8 * (i % 16) -: 8] = b;
                if ((i % 16 == 15) || (i == len - 1 && cut == 0)) begin
                    exp_data.push_back(beat);
                    beat = '0;
                    nb++;
                end
            end
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_sof   = 1'b0;
                bus.in_eof   = 1'b0;
                @(posedge clk); #1;
            end
            bus.in_valid   = 1'b1;
            bus.in_data    = b;
            bus.in_sof     = (i == 0);
            bus.in_eof     = (i == len - 1);
            bus.in_portmap = pm;
            bus.i_cell_bp  = (i == 0) ? bp_sof : bp_mid;
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_eof    = 1'b0;
        bus.i_cell_bp = 1'b0;
        if (admit && cut == 0) begin
            while (nb < MIN_BEATS) begin
                exp_data.push_back('0);
                nb++;
            end
            exp_desc.push_back({(len <= 16 * MAX_BEATS), 4'b0, pm, 8'(nb)});
            cnt_frames++;
        end else if (!admit) begin
            if (bp_sof || force_drop) cnt_bp++;
            else cnt_nomap++;
        end
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 400 && (exp_data.size() != 0 || exp_desc.size() != 0); k++)
            @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        check({tag, "_data_left"}, 128'(exp_data.size()), 128'(0));
        check({tag, "_desc_left"}, 128'(exp_desc.size()), 128'(0));
        check({tag, "_stat_frames"}, 128'(stat_frames), 128'(exp_stat(cnt_frames)));
        check({tag, "_stat_bp"}, 128'(stat_drop_bp), 128'(exp_stat(cnt_bp)));
        check({tag, "_stat_nomap"}, 128'(stat_drop_nomap), 128'(exp_stat(cnt_nomap)));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data_din"}, bus.i_cell_data_fifo_din, 128'(0));
        check({tag, "_data_wr"}, 128'(bus.i_cell_data_fifo_wr), 128'(0));
        check({tag, "_ptr_din"}, 128'(bus.i_cell_ptr_fifo_din), 128'(0));
        check({tag, "_ptr_wr"}, 128'(bus.i_cell_ptr_fifo_wr), 128'(0));
        check({tag, "_stats"}, 128'({stat_frames, stat_drop_bp, stat_drop_nomap}), 128'(0));
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_data    = '0;
        bus.in_valid   = 1'b0;
        bus.in_sof     = 1'b0;
        bus.in_eof     = 1'b0;
        bus.in_portmap = '0;
        bus.i_cell_bp  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        send_frame(64, 4'b0011, 1'b0, 1'b0, 1'b0, 0);
        drain("f64");
        send_frame(20, 4'b0001, 1'b0, 1'b0, 1'b0, 0);
        drain("f20_pad");
        send_frame(30, 4'b0110, 1'b1, 1'b0, 1'b0, 0);
        drain("bp_drop");
        send_frame(64, 4'b0101, 1'b0, 1'b1, 1'b0, 0);
        drain("bp_mid_pass");
        send_frame(40, 4'b0000, 1'b0, 1'b0, 1'b0, 0);
        drain("nomap_drop");
        send_frame(1, 4'b1000, 1'b0, 1'b0, 1'b0, 0);
        drain("f1");
        send_frame(20, 4'b0010, 1'b0, 1'b0, 1'b0, 0);
        send_frame(30, 4'b0001, 1'b0, 1'b0, 1'b1, 0);
        drain("sof_in_pad");
        send_frame(256, 4'b1111, 1'b0, 1'b0, 1'b0, 0);
        drain("f256");
        send_frame(2000, 4'b0100, 1'b0, 1'b0, 1'b0, 0);
        drain("f2000_sat");

        send_frame(64, 4'b1001, 1'b0, 1'b0, 1'b0, 40);
        check("pre_rst_data_left", 128'(exp_data.size()), 128'(0));
        #2;
        rst = 1'b1;
        #1;
        check_zero("mid_rst");
        cnt_frames = 0;
        cnt_bp     = 0;
        cnt_nomap  = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_frame(64, 4'b0011, 1'b0, 1'b0, 1'b0, 0);
        drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
